colorclk_dds: RTL and testbench
===============================

Name: colorclk_dds

Overview:
- Digitally synthesised colour-subcarrier clock (4x Fsc) for the composite encoder path.
- Runs on the dedicated colour master clock and produces the clkcolor4x level that the VGA/composite scandoubler stage consumes.
- Selects PAL, NTSC, PAL-N or PAL-M from mode/altern inputs that arrive from the system-clock domain.
- Retunes only at accumulator wrap, so no runt pulse reaches the encoder.

Parameters:
- ACC_W, 32: phase accumulator width in bits (min 4).
- TW_PAL, 761689901: tuning word for mode=0, altern=0 (PAL, 17.734475 MHz at a 100 MHz clk).
- TW_PALN, 615396432: tuning word for mode=0, altern=1 (PAL-N 4x).
- TW_NTSC, 614961234: tuning word for mode=1, altern=0 (NTSC, 14.318182 MHz).
- TW_PALM, 614289650: tuning word for mode=1, altern=1 (PAL-M 4x).
- SETTLE_W, 10: width of the settle counter behind the stable output.

Ports:
- clk  in  1  colour master clock (mcolorclk)
- rst  in  1  asynchronous reset, active high
- mode  in  1  0 = PAL family, 1 = NTSC family; asynchronous to clk
- altern  in  1  alternate standard within the family; asynchronous
- enable  in  1  1 = generate; 0 = hold output high; asynchronous
- clkcolor4x  out  1  subcarrier x4 square wave, registered
- stable  out  1  1 = tuning unchanged for 2^SETTLE_W cycles
- tw_active  out  ACC_W  tuning word currently in use, for debug readback

Behaviour:
- Reset (async, rst=1):
  - acc, synchronisers and settle counter clear to 0.
  - tw_active loads TW_PAL.
  - clkcolor4x=1, stable=0.
- Input synchronisation:
  - mode, altern and enable each pass through a 2-FF synchroniser (reset 0).
  - Only the synchronised copies are used (m_s, a_s, e_s).
  - An input change therefore reaches logic 2 clk edges later.
- Word selection, combinational from {m_s,a_s}:
  - 00 → TW_PAL
  - 01 → TW_PALN
  - 10 → TW_NTSC
  - 11 → TW_PALM
  - The result is tw_pending.
- Accumulator:
  - Each cycle with e_s=1: {carry, acc_next} = acc + tw_active, ACC_W+1 bit add; acc <= acc_next. Wrap is modulo 2^ACC_W.
  - With e_s=0: acc clears to 0 and tw_active loads tw_pending immediately.
- Retune rule:
  - With e_s=1, tw_active <= tw_pending only on a cycle where carry=1 (wrap).
  - The add that wraps still uses the old word; the new word applies from the next cycle.
  - If the selection changes several times between wraps, the value present at the wrap cycle wins.
- Output:
  - clkcolor4x <= e_s ? acc_next[ACC_W-1] : 1.
  - This is a registered MSB, one cycle after the add.
  - Duty is within one clk period of 50 %.
- Settle counter:
  - Clears whenever tw_pending != tw_active, or e_s=0.
  - Otherwise it increments and saturates at all-ones.
  - stable = counter all-ones, registered.
- Enable edges:
  - Rising e_s: acc starts from 0, so the first output high occurs once acc crosses 2^(ACC_W-1).
  - Falling e_s: clkcolor4x goes high on the next edge, with no partial-period glitch low.
- Reset mid-operation returns all state to the reset values instantly (async), with no further edges.
- tw_active = 0 (parameter misuse) leaves the output frozen; this is legal and not flagged.

Test Plan:
- ACC_W=8, TW_PAL=64, enable=1, mode=altern=0 → clkcolor4x period exactly 4 clk (2 high, 2 low); stable rises after 2^SETTLE_W+2 cycles.
- ACC_W=8, TW_NTSC=32; toggle mode 0→1 mid-period → tw_active changes only on the cycle after the next carry; no high or low phase shorter than 2 clk; stable drops and re-asserts after the settle time.
- mode toggled 0→1→0 within 3 cycles between wraps → tw_active stays at TW_PAL; stable drops then recovers.
- enable 1→0 → clkcolor4x=1 on the 3rd clk edge after the change (2 sync + 1 output register); acc=0; tw_active = tw_pending; re-enable → output low until acc ≥ 128 (ACC_W=8).
- Assert rst asynchronously mid-period → clkcolor4x=1, stable=0, tw_active=TW_PAL immediately, before any clk edge.
- Default parameters, 100 MHz clk, 10^6 cycles, count rising edges per mode/altern → PAL ≈ 177345, PAL-N ≈ 143282, NTSC ≈ 143182, PAL-M ≈ 143024 (±1).

Source files
------------

// File: rtl/colorclk_dds.sv
// colorclk_dds: 4x colour-subcarrier DDS, retuned only at accumulator wrap, with a settle flag
module colorclk_dds #(
  parameter int ACC_W = 32,
  parameter logic [ACC_W-1:0] TW_PAL  = ACC_W'(761689901),
  parameter logic [ACC_W-1:0] TW_PALN = ACC_W'(615396432),
  parameter logic [ACC_W-1:0] TW_NTSC = ACC_W'(614961234),
  parameter logic [ACC_W-1:0] TW_PALM = ACC_W'(614289650),
  parameter int SETTLE_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode,
  input  logic             altern,
  input  logic             enable,
  output logic             clkcolor4x,
  output logic             stable,
  output logic [ACC_W-1:0] tw_active
);
  logic [1:0]          r_m_sync, r_a_sync, r_e_sync;
  logic [ACC_W-1:0]    r_acc;
  logic [SETTLE_W-1:0] r_settle;
  logic                w_m_s, w_a_s, w_e_s;
  logic [ACC_W-1:0]    w_tw_pending;
  logic [ACC_W:0]      w_sum;
  always_comb begin
    w_m_s = r_m_sync[1];
    w_a_s = r_a_sync[1];
    w_e_s = r_e_sync[1];
    w_tw_pending = w_m_s ? (w_a_s ? TW_PALM : TW_NTSC) : (w_a_s ? TW_PALN : TW_PAL);
    w_sum = {1'b0, r_acc} + {1'b0, tw_active};
  end
  // the wrapping add still uses the old word, so a retune never shortens a phase
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_m_sync   <= '0;
      r_a_sync   <= '0;
      r_e_sync   <= '0;
      r_acc      <= '0;
      r_settle   <= '0;
      tw_active  <= TW_PAL;
      clkcolor4x <= 1'b1;
      stable     <= 1'b0;
    end else begin
      r_m_sync   <= {r_m_sync[0], mode};
      r_a_sync   <= {r_a_sync[0], altern};
      r_e_sync   <= {r_e_sync[0], enable};
      r_acc      <= w_e_s ? w_sum[ACC_W-1:0] : '0;
      if (!w_e_s || w_sum[ACC_W]) tw_active <= w_tw_pending;
      clkcolor4x <= w_e_s ? w_sum[ACC_W-1] : 1'b1;
      r_settle   <= (!w_e_s || w_tw_pending != tw_active) ? '0 : r_settle + SETTLE_W'(~&r_settle);
      stable     <= &r_settle;
    end
endmodule

// File: tb/tb_colorclk_dds.sv
// tb_colorclk_dds: directed checks on a small 8-bit instance plus frequency counts on a default instance
module tb_colorclk_dds;
  logic clk = 1'b0;
  logic rst, mode, altern, enable;
  logic clk4x, stable;
  logic [7:0] tw;
  logic d_mode, d_alt, d_en;
  logic o2, s2;
  logic [31:0] tw2;
  int total = 0, bad = 0, e = 0;
  always #5 clk = ~clk;
  colorclk_dds #(.ACC_W(8), .TW_PAL(8'd64), .TW_PALN(8'd48), .TW_NTSC(8'd32), .TW_PALM(8'd16), .SETTLE_W(4)) dut (
    .clk(clk), .rst(rst), .mode(mode), .altern(altern), .enable(enable),
    .clkcolor4x(clk4x), .stable(stable), .tw_active(tw)
  );
  colorclk_dds dut2 (
    .clk(clk), .rst(rst), .mode(d_mode), .altern(d_alt), .enable(d_en),
    .clkcolor4x(o2), .stable(s2), .tw_active(tw2)
  );
  task automatic tick;
    @(posedge clk);
    #1;
    e++;
  endtask
  task automatic test_reset;
    #2;
    total++; if (clk4x !== 1'b1) begin bad++; $display("FAIL reset_out got=%b exp=1", clk4x); end
    total++; if (stable !== 1'b0) begin bad++; $display("FAIL reset_stable got=%b exp=0", stable); end
    total++; if (tw !== 8'd64) begin bad++; $display("FAIL reset_tw got=%0d exp=64", tw); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    enable = 1'b1;
    e = 0;
  endtask
  task automatic test_pal_period;
    logic exp_o;
    for (int i = 1; i <= 20; i++) begin
      tick();
      exp_o = (e < 3) || ((e - 3) % 4 == 1) || ((e - 3) % 4 == 2);
      total++; if (clk4x !== exp_o) begin bad++; $display("FAIL pal_out e=%0d got=%b exp=%b", e, clk4x, exp_o); end
      total++; if (stable !== (e >= 18)) begin bad++; $display("FAIL pal_stable e=%0d got=%b exp=%b", e, stable, e >= 18); end
      total++; if (tw !== 8'd64) begin bad++; $display("FAIL pal_tw e=%0d got=%0d exp=64", e, tw); end
    end
  endtask
  task automatic test_retune;
    logic [7:0] exp_tw;
    mode = 1'b1;
    while (e < 42) begin
      tick();
      exp_tw = (e <= 25) ? 8'd64 : 8'd32;
      total++; if (tw !== exp_tw) begin bad++; $display("FAIL retune_tw e=%0d got=%0d exp=%0d", e, tw, exp_tw); end
      if (e >= 26) begin
        total++; if (clk4x !== ((e - 26) % 8 >= 4)) begin bad++; $display("FAIL retune_out e=%0d got=%b exp=%b", e, clk4x, (e - 26) % 8 >= 4); end
      end
      if (e >= 24) begin
        total++; if (stable !== (e >= 42)) begin bad++; $display("FAIL retune_stable e=%0d got=%b exp=%b", e, stable, e >= 42); end
      end
    end
  endtask
  task automatic test_glitch;
    logic exp_s;
    mode = 1'b0;
    while (e < 61) begin
      tick();
      if (e == 43) mode = 1'b1;
      exp_s = !(e >= 46 && e <= 60);
      total++; if (tw !== 8'd32) begin bad++; $display("FAIL glitch_tw e=%0d got=%0d exp=32", e, tw); end
      total++; if (stable !== exp_s) begin bad++; $display("FAIL glitch_stable e=%0d got=%b exp=%b", e, stable, exp_s); end
      total++; if (clk4x !== ((e - 26) % 8 >= 4)) begin bad++; $display("FAIL glitch_out e=%0d got=%b exp=%b", e, clk4x, (e - 26) % 8 >= 4); end
    end
  endtask
  task automatic test_enable;
    logic [7:0] exp_tw;
    logic exp_o;
    while (e < 65) begin
      tick();
      total++; if (clk4x !== ((e - 26) % 8 >= 4)) begin bad++; $display("FAIL pre_dis_out e=%0d got=%b exp=%b", e, clk4x, (e - 26) % 8 >= 4); end
    end
    enable = 1'b0;
    mode = 1'b0;
    while (e < 76) begin
      tick();
      if (e == 70) enable = 1'b1;
      exp_tw = (e <= 67) ? 8'd32 : 8'd64;
      exp_o = !(e == 66 || e == 67 || e == 73 || e == 76);
      total++; if (clk4x !== exp_o) begin bad++; $display("FAIL enable_out e=%0d got=%b exp=%b", e, clk4x, exp_o); end
      total++; if (tw !== exp_tw) begin bad++; $display("FAIL enable_tw e=%0d got=%0d exp=%0d", e, tw, exp_tw); end
      if (e >= 69 && e <= 72) begin
        total++; if (stable !== 1'b0) begin bad++; $display("FAIL enable_stable e=%0d got=%b exp=0", e, stable); end
      end
    end
  endtask
  task automatic test_async_reset;
    mode = 1'b1;
    while (e < 82) tick();
    total++; if (tw !== 8'd32) begin bad++; $display("FAIL pre_rst_tw got=%0d exp=32", tw); end
    total++; if (clk4x !== 1'b0) begin bad++; $display("FAIL pre_rst_out got=%b exp=0", clk4x); end
    #3;
    rst = 1'b1;
    #1;
    total++; if (clk4x !== 1'b1) begin bad++; $display("FAIL arst_out got=%b exp=1", clk4x); end
    total++; if (stable !== 1'b0) begin bad++; $display("FAIL arst_stable got=%b exp=0", stable); end
    total++; if (tw !== 8'd64) begin bad++; $display("FAIL arst_tw got=%0d exp=64", tw); end
    tick();
    tick();
    total++; if (clk4x !== 1'b1 || tw !== 8'd64) begin bad++; $display("FAIL arst_hold out=%b tw=%0d exp out=1 tw=64", clk4x, tw); end
    rst = 1'b0;
  endtask
  task automatic test_freq;
    logic [31:0] exp_tw[4] = '{32'd761689901, 32'd615396432, 32'd614961234, 32'd614289650};
    int exp_cnt[4] = '{887, 716, 716, 715};
    int cnt, w;
    logic prev;
    d_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      d_mode = i[1];
      d_alt = i[0];
      w = 0;
      while (tw2 !== exp_tw[i] && w < 100) begin tick(); w++; end
      total++; if (tw2 !== exp_tw[i]) begin bad++; $display("FAIL freq_tw mode=%0d got=%0d exp=%0d", i, tw2, exp_tw[i]); end
      cnt = 0;
      prev = o2;
      for (int k = 0; k < 5000; k++) begin
        tick();
        if (o2 && !prev) cnt++;
        prev = o2;
      end
      total++; if (cnt < exp_cnt[i] - 2 || cnt > exp_cnt[i] + 2) begin bad++; $display("FAIL freq_count mode=%0d got=%0d exp=%0d+-2", i, cnt, exp_cnt[i]); end
    end
  endtask
  initial begin
    rst = 1'b1; mode = 1'b0; altern = 1'b0; enable = 1'b0;
    d_mode = 1'b0; d_alt = 1'b0; d_en = 1'b0;
    test_reset();
    test_pal_period();
    test_retune();
    test_glitch();
    test_enable();
    test_async_reset();
    test_freq();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
